// File: rtl/reg_file_pkg.sv
// Shared defaults and typedefs for the scoreboarded register file.
// Optional feature: REG_FILE_SB_BYPASS_EN (write-to-read forwarding in the top level).
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // True when a strobe targets a real register; register 0 is hardwired.
  function automatic logic addr_live(input logic en, input logic [31:0] addr);
    return en && (addr != 32'd0);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, issue/flush scoreboard controls and NRD read ports.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);
  localparam int AW = $clog2(NREGS);

  logic                          write_enable;
  logic [AW-1:0]                 write_addr;
  logic [XLEN-1:0]               write_data;
  logic [NRD-1:0][AW-1:0]        read_addr;
  logic [NRD-1:0][XLEN-1:0]      read_data;
  logic [NRD-1:0]                read_busy;
  logic                          issue_valid;
  logic [AW-1:0]                 issue_addr;
  logic                          flush;

  modport master (
    output write_enable, write_addr, write_data,
    output read_addr,
    input  read_data, read_busy,
    output issue_valid, issue_addr, flush
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  read_addr,
    output read_data, read_busy,
    input  issue_valid, issue_addr, flush
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit vector: flush beats set, set beats clear; bit 0 is permanently clear.
module reg_file_sb_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_en && (set_addr == AW'(gi));
        assign clr_hit = clr_en && (clr_addr == AW'(gi));
        // A new producer claiming the register outranks the retiring writer.
        assign busy_next[gi] = flush   ? 1'b0 :
                               set_hit ? 1'b1 :
                               clr_hit ? 1'b0 :
                                         busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and combinational read ports.
// Define REG_FILE_SB_BYPASS_EN to forward an in-flight write to same-cycle reads.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             write_live;
  logic             issue_live;

  assign write_live = addr_live(bus.write_enable, 32'(bus.write_addr));
  assign issue_live = addr_live(bus.issue_valid,  32'(bus.issue_addr));

  // Register 0 is reset like the rest and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_live) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  reg_file_sb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_live),
    .set_addr (bus.issue_addr),
    .clr_en   (write_live),
    .clr_addr (bus.write_addr),
    .flush    (bus.flush),
    .busy     (busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic          fwd;

      assign ra = bus.read_addr[gi];

`ifdef REG_FILE_SB_BYPASS_EN
      // Reset gates forwarding so reads stay zero while rst_n is low.
      assign fwd = rst_n && write_live && (bus.write_addr == ra);
`else
      assign fwd = 1'b0;
`endif

      assign bus.read_data[gi] = (ra == '0) ? '0             :
                                 fwd        ? bus.write_data :
                                              regs[ra];
      assign bus.read_busy[gi] = fwd ? 1'b0 : busy[ra];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, write/read, scoreboard set/clear/flush, bypass.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.write_data   = '0;
    bus.issue_valid  = 1'b0;
    bus.issue_addr   = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    bus.write_enable = 1'b1;
    bus.write_addr   = a;
    bus.write_data   = d;
  endtask

  task automatic do_issue(input reg_addr_t a);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = a;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    bus.read_addr[0] = a0;
    bus.read_addr[1] = a1;
    #1;
  endtask

  reg_data_t byp_exp_data;
  logic      byp_exp_busy;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();
    set_rd(5'd5, 5'd31);
    #11;
    check("por_data0", 64'(bus.read_data[0]), 64'h0);
    check("por_busy1", 64'(bus.read_busy[1]), 64'h0);

    // First edge after release must already take the write.
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd2, 32'h0000_0ABC);
    tick();
    idle();
    set_rd(5'd2, 5'd2);
    check("first_edge_x2", 64'(bus.read_data[0]), 64'hABC);

    // Write then read on both ports.
    do_write(5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_rd(5'd5, 5'd5);
    check("x5_data_p0", 64'(bus.read_data[0]), 64'hDEAD_BEEF);
    check("x5_data_p1", 64'(bus.read_data[1]), 64'hDEAD_BEEF);
    check("x5_busy_p0", 64'(bus.read_busy[0]), 64'h0);
    check("x5_busy_p1", 64'(bus.read_busy[1]), 64'h0);

    do_write(5'd0, 32'h0000_1234);
    do_issue(5'd0);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    check("x0_data", 64'(bus.read_data[0]), 64'h0);
    check("x0_busy", 64'(bus.read_busy[1]), 64'h0);

    // Scoreboard set, then clear by write.
    do_issue(5'd7);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    check("x7_busy_p0", 64'(bus.read_busy[0]), 64'h1);
    check("x7_busy_p1", 64'(bus.read_busy[1]), 64'h1);
    do_write(5'd7, 32'h55);
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    check("x7_clr_busy", 64'(bus.read_busy[0]), 64'h0);
    check("x7_clr_data", 64'(bus.read_data[1]), 64'h55);

    // Same-cycle issue and write to one register: set wins.
    do_issue(5'd9);
    do_write(5'd9, 32'hA5);
    tick();
    idle();
    set_rd(5'd9, 5'd9);
    check("x9_data", 64'(bus.read_data[0]), 64'hA5);
    check("x9_busy", 64'(bus.read_busy[1]), 64'h1);

    // Different addresses in one cycle act independently.
    do_issue(5'd11);
    do_write(5'd12, 32'h77);
    tick();
    idle();
    set_rd(5'd11, 5'd12);
    check("x11_busy", 64'(bus.read_busy[0]), 64'h1);
    check("x12_busy", 64'(bus.read_busy[1]), 64'h0);
    check("x12_data", 64'(bus.read_data[1]), 64'h77);

    // Flush clears everything, overriding a same-cycle issue.
    do_issue(5'd3); tick();
    do_issue(5'd4); tick();
    do_issue(5'd6); tick();
    idle();
    set_rd(5'd3, 5'd6);
    check("x3_busy_pre", 64'(bus.read_busy[0]), 64'h1);
    check("x6_busy_pre", 64'(bus.read_busy[1]), 64'h1);
    bus.flush = 1'b1;
    do_issue(5'd8);
    do_write(5'd13, 32'h99);
    tick();
    idle();
    set_rd(5'd3, 5'd4);
    check("x3_busy_fl", 64'(bus.read_busy[0]), 64'h0);
    check("x4_busy_fl", 64'(bus.read_busy[1]), 64'h0);
    set_rd(5'd6, 5'd8);
    check("x6_busy_fl", 64'(bus.read_busy[0]), 64'h0);
    check("x8_busy_fl", 64'(bus.read_busy[1]), 64'h0);
    set_rd(5'd9, 5'd13);
    check("x9_busy_fl", 64'(bus.read_busy[0]), 64'h0);
    check("x9_data_fl", 64'(bus.read_data[0]), 64'hA5);
    check("x13_data_fl", 64'(bus.read_data[1]), 64'h99);

    // Bypass: x10 holds an old value and is busy, then written while read.
    do_write(5'd10, 32'h1111_1111);
    tick();
    idle();
    do_issue(5'd10);
    tick();
    idle();
    do_write(5'd10, 32'hCAFE_F00D);
    set_rd(5'd10, 5'd10);
`ifdef REG_FILE_SB_BYPASS_EN
    byp_exp_data = 32'hCAFE_F00D;
    byp_exp_busy = 1'b0;
`else
    byp_exp_data = 32'h1111_1111;
    byp_exp_busy = 1'b1;
`endif
    check("x10_byp_data_p0", 64'(bus.read_data[0]), 64'(byp_exp_data));
    check("x10_byp_data_p1", 64'(bus.read_data[1]), 64'(byp_exp_data));
    check("x10_byp_busy", 64'(bus.read_busy[0]), 64'(byp_exp_busy));
    tick();
    idle();
    set_rd(5'd10, 5'd10);
    check("x10_post_data", 64'(bus.read_data[0]), 64'hCAFE_F00D);
    check("x10_post_busy", 64'(bus.read_busy[1]), 64'h0);

    // Mid-run reset: asynchronous clear and a discarded write across an edge.
    do_issue(5'd14);
    tick();
    idle();
    do_write(5'd20, 32'h2020_2020);
    do_issue(5'd21);
    rst_n = 1'b0;
    set_rd(5'd5, 5'd14);
    check("rst_async_x5", 64'(bus.read_data[0]), 64'h0);
    check("rst_async_x14b", 64'(bus.read_busy[1]), 64'h0);
    tick();
    idle();
    for (int a = 0; a < NREGS; a++) begin
      set_rd(reg_addr_t'(a), reg_addr_t'(NREGS - 1 - a));
      check($sformatf("rst_d0_x%0d", a), 64'(bus.read_data[0]), 64'h0);
      check($sformatf("rst_d1_x%0d", NREGS - 1 - a), 64'(bus.read_data[1]), 64'h0);
      check($sformatf("rst_b0_x%0d", a), 64'(bus.read_busy[0]), 64'h0);
      check($sformatf("rst_b1_x%0d", NREGS - 1 - a), 64'(bus.read_busy[1]), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_issue(5'd21);
    tick();
    idle();
    set_rd(5'd20, 5'd21);
    check("post_rst_x20", 64'(bus.read_data[0]), 64'h0);
    check("post_rst_x21b", 64'(bus.read_busy[1]), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count (power of 2, at least 2); AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, meaning read port count (1..4).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port write_enable, input, 1 bit, register write strobe.
REQ-007 The block SHALL have port write_addr, input, AW bits, destination register.
REQ-008 The block SHALL have port write_data, input, XLEN bits, data to write.
REQ-009 The block SHALL have port read_addr, input, NRD x AW bits, one read address per port.
REQ-010 The block SHALL have port read_data, output, NRD x XLEN bits, per-port read data.
REQ-011 The block SHALL have port read_busy, output, NRD bits, per-port scoreboard pending flag.
REQ-012 The block SHALL have port issue_valid, input, 1 bit, marks issue_addr as having a pending producer.
REQ-013 The block SHALL have port issue_addr, input, AW bits, register being claimed.
REQ-014 The block SHALL have port flush, input, 1 bit, synchronous clear of all busy bits.

Function
REQ-015 Reads SHALL be combinational: read_data[i] = reg[read_addr[i]] and read_busy[i] = busy[read_addr[i]], with zero latency.
REQ-016 Register 0 SHALL always read 0 with read_busy 0; writes and issues to address 0 SHALL be ignored.
REQ-017 write_enable=1 with write_addr!=0 SHALL update reg[write_addr] at the next rising edge and clear busy[write_addr] there.
REQ-018 issue_valid=1 with issue_addr!=0 SHALL set busy[issue_addr] at the next rising edge.
REQ-019 When issue and write target the same address in one cycle, the set SHALL win: data is written and busy ends at 1.
REQ-020 When issue and write target different addresses in one cycle, both SHALL take effect independently.
REQ-021 flush=1 SHALL clear every busy bit at the next edge, overriding any issue in the same cycle; a write in that cycle SHALL still commit its data.
REQ-022 Any number of read ports SHALL be able to address the same register with identical results.
REQ-023 The block SHALL apply no backpressure; every request is accepted in the cycle it is presented.

Reset
REQ-024 While rst_n=0, all registers SHALL be 0 and all busy bits SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 During reset and after reset, every read_data SHALL be 0 and every read_busy SHALL be 0 until the first write or issue.
REQ-026 Reset asserted mid-operation SHALL discard pending writes and issues in that cycle.
REQ-027 The first edge after rst_n rises SHALL process inputs normally.

Configuration
REQ-028 The macro REG_FILE_SB_BYPASS_EN, when defined, SHALL make a read whose address matches an active nonzero write_addr return write_data and a read_busy of 0 in the same cycle; if an issue to that address is also active, read_busy SHALL be 0 for that cycle only.
REQ-029 When REG_FILE_SB_BYPASS_EN is not defined, such a read SHALL return the old register value and the old busy bit.

Structure
REQ-030 The package reg_file_pkg SHALL hold the XLEN and NREGS defaults, the reg_addr_t typedef (AW bits) and the reg_data_t typedef (XLEN bits).
REQ-031 The busy-bit vector, with its set, clear and flush priority, SHALL be the sub-module reg_file_sb_scoreboard; data storage and read muxing SHALL stay in the top level.

Verification
REQ-032 The bench SHALL cover reset: hold rst_n=0 mid-run, then read all addresses on both ports; required response is read_data=0 and read_busy=0, asynchronously.
REQ-033 The bench SHALL cover write then read: write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 next cycle; required response is 0xDEADBEEF on both with busy 0; writing 0x1234 to x0 must still read 0.
REQ-034 The bench SHALL cover the scoreboard: issue x7, then read x7; required response is busy=1; write 0x55 to x7 and the following cycle must give busy=0 and data 0x55.
REQ-035 The bench SHALL cover a same-cycle issue and write to x9 with data 0xA5; required response next cycle is data 0xA5 and busy=1.
REQ-036 The bench SHALL cover flush: issue x3, x4 and x6, then flush together with an issue of x8; required response is all busy 0, including x8.
REQ-037 The bench SHALL cover the bypass: write 0xCAFEF00D to x10 and read x10 in the same cycle; required response is 0xCAFEF00D with REG_FILE_SB_BYPASS_EN defined, and the prior value without it.
